// File: rtl/global_table_update_ctrl_if.sv
// -----------------------------------------------------------------------------
// global_table_update_ctrl_if
//
// Purpose: bundles the fetch lookup, retire resolve, prediction result and
// shared table RAM port signals of global_table_update_ctrl.
//
// Handshakes: a lookup (lookup_valid/lookup_ready) or a resolve
// (resolve_valid/resolve_ready) transfers on a rising clock edge where both
// valid and ready are high. The requester holds valid and its payload until
// that transfer. Ready never depends on valid in the same cycle.
//
// Modports:
//   slave  - the controller (takes requests, drives the table port)
//   master - the environment (fetch, retire and the table RAM)
//
// Parameter HIST_W: path-history / table index width.
// -----------------------------------------------------------------------------
interface global_table_update_ctrl_if #(
    parameter int HIST_W = 12
);
    logic              lookup_valid;
    logic [HIST_W-1:0] lookup_hist;
    logic              lookup_ready;

    logic              pred_valid;
    logic              global_bit;
    logic              choice_bit;

    logic              resolve_valid;
    logic [HIST_W-1:0] resolve_hist;
    logic              resolve_taken;
    logic              resolve_global_ok;
    logic              resolve_local_ok;
    logic              resolve_ready;

    logic              tbl_en;
    logic              tbl_we;
    logic [HIST_W-1:0] tbl_addr;
    logic [1:0]        tbl_wdata_g;
    logic [1:0]        tbl_wdata_c;
    logic [1:0]        tbl_rdata_g;
    logic [1:0]        tbl_rdata_c;

    logic              init_done;

    modport slave (
        input  lookup_valid, lookup_hist,
        input  resolve_valid, resolve_hist, resolve_taken,
        input  resolve_global_ok, resolve_local_ok,
        input  tbl_rdata_g, tbl_rdata_c,
        output lookup_ready, pred_valid, global_bit, choice_bit,
        output resolve_ready,
        output tbl_en, tbl_we, tbl_addr, tbl_wdata_g, tbl_wdata_c,
        output init_done
    );

    modport master (
        output lookup_valid, lookup_hist,
        output resolve_valid, resolve_hist, resolve_taken,
        output resolve_global_ok, resolve_local_ok,
        output tbl_rdata_g, tbl_rdata_c,
        input  lookup_ready, pred_valid, global_bit, choice_bit,
        input  resolve_ready,
        input  tbl_en, tbl_we, tbl_addr, tbl_wdata_g, tbl_wdata_c,
        input  init_done
    );
endinterface

// File: rtl/global_table_update_ctrl.sv
// -----------------------------------------------------------------------------
// global_table_update_ctrl
//
// Purpose: schedules the single port of the shared global-pattern / choice
// counter RAM (2^HIST_W entries, two 2-bit counters each). Fetch lookups get
// one read per cycle; retire updates are queued and applied as a
// read (IDLE) + write (WR) pair. After reset the whole table is cleared by a
// write sweep before any request is accepted.
//
// Ports:
//   clock     - system clock
//   reset     - asynchronous, active-high reset
//   bus       - global_table_update_ctrl_if.slave (lookup, resolve,
//               prediction, table port, init_done)
//   dbgState  - current FSM state (0 INIT, 1 IDLE, 2 WR)
//   stat_updates, stat_lookup_stalls - only with UPD_STATS_EN defined;
//               saturating counts of WR cycles and of stalled lookups
//
// Parameters: HIST_W (index width), QDEPTH (update queue depth, power of 2,
// >= 2).
//
// Build option: define UPD_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module global_table_update_ctrl #(
    parameter int HIST_W = 12,
    parameter int QDEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    global_table_update_ctrl_if.slave   bus,
    output logic [1:0]                  dbgState
`ifdef UPD_STATS_EN
    ,
    output logic [15:0]                 stat_updates,
    output logic [15:0]                 stat_lookup_stalls
`endif
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam logic [HIST_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WR   = 2'd2
    } state_t;

    typedef struct packed {
        logic [HIST_W-1:0] hist;
        logic              taken;
        logic              globalOk;
        logic              localOk;
    } upd_t;

    state_t            state;
    upd_t              queueMem [QDEPTH];
    logic [PTR_W:0]    wrPtr;
    logic [PTR_W:0]    rdPtr;
    upd_t              head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic              sweepEn;
    logic [HIST_W-1:0] sweepAddr;
    logic              initDone;

    logic              lookupReady;
    logic              resolveReady;
    logic              lookupFire;

    // A lookup read issued this cycle returns data next cycle; predPending
    // marks that cycle, heldG/heldC keep the last delivered bits afterwards.
    logic              predPending;
    logic              heldG;
    logic              heldC;

    logic              tblEn;
    logic              tblWe;
    logic [HIST_W-1:0] tblAddr;
    logic [1:0]        nextG;
    logic [1:0]        nextC;
    logic [1:0]        wdataG;
    logic [1:0]        wdataC;

    // ------------------------------------------------------------------ queue
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                   (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign head  = queueMem[rdPtr[PTR_W-1:0]];

    // Ready is derived from registered state only, so a full queue refuses
    // even in the cycle its head is popped.
    assign resolveReady = initDone & ~full;
    assign push         = bus.resolve_valid & resolveReady;
    assign pop          = (state == WR);

    // A full queue takes the port away from fetch so updates cannot starve.
    assign lookupReady  = (state == IDLE) & ~full;
    assign lookupFire   = bus.lookup_valid & lookupReady;

    always_ff @(posedge clock) begin
        if (push) begin
            queueMem[wrPtr[PTR_W-1:0]] <= '{hist:     bus.resolve_hist,
                                            taken:    bus.resolve_taken,
                                            globalOk: bus.resolve_global_ok,
                                            localOk:  bus.resolve_local_ok};
        end
    end

    // ------------------------------------------------ counter update values
    always_comb begin
        nextG = bus.tbl_rdata_g;
        nextC = bus.tbl_rdata_c;
        if (head.taken) begin
            if (bus.tbl_rdata_g != 2'd3) nextG = bus.tbl_rdata_g + 2'd1;
        end else begin
            if (bus.tbl_rdata_g != 2'd0) nextG = bus.tbl_rdata_g - 2'd1;
        end
        // Choice moves toward whichever predictor alone was right.
        if (head.globalOk && !head.localOk) begin
            if (bus.tbl_rdata_c != 2'd3) nextC = bus.tbl_rdata_c + 2'd1;
        end else if (!head.globalOk && head.localOk) begin
            if (bus.tbl_rdata_c != 2'd0) nextC = bus.tbl_rdata_c - 2'd1;
        end
    end

    // ------------------------------------------------------- table port mux
    always_comb begin
        tblEn   = 1'b0;
        tblWe   = 1'b0;
        tblAddr = '0;
        wdataG  = 2'd0;
        wdataC  = 2'd0;
        case (state)
            INIT: begin
                // sweepEn is low in the first cycle after reset, so the port
                // stays quiet while reset is asserted.
                tblEn   = sweepEn;
                tblWe   = sweepEn;
                tblAddr = sweepAddr;
            end
            IDLE: begin
                if (full) begin
                    tblEn   = 1'b1;
                    tblAddr = head.hist;
                end else if (bus.lookup_valid) begin
                    tblEn   = 1'b1;
                    tblAddr = bus.lookup_hist;
                end else if (!empty) begin
                    tblEn   = 1'b1;
                    tblAddr = head.hist;
                end
            end
            WR: begin
                tblEn   = 1'b1;
                tblWe   = 1'b1;
                tblAddr = head.hist;
                wdataG  = nextG;
                wdataC  = nextC;
            end
            default: begin
                tblEn = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            sweepEn     <= 1'b0;
            sweepAddr   <= '0;
            initDone    <= 1'b0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            predPending <= 1'b0;
            heldG       <= 1'b0;
            heldC       <= 1'b0;
        end else begin
            predPending <= lookupFire;
            if (predPending) begin
                heldG <= bus.tbl_rdata_g[1];
                heldC <= bus.tbl_rdata_c[1];
            end
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;

            case (state)
                INIT: begin
                    if (!sweepEn) begin
                        sweepEn <= 1'b1;
                    end else if (sweepAddr == LAST_ADDR) begin
                        sweepEn  <= 1'b0;
                        initDone <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        sweepAddr <= sweepAddr + 1'b1;
                    end
                end
                IDLE: begin
                    // Same conditions that issued the head read in the mux.
                    if (full || (!bus.lookup_valid && !empty)) state <= WR;
                end
                WR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    assign bus.lookup_ready  = lookupReady;
    assign bus.resolve_ready = resolveReady;
    assign bus.init_done     = initDone;
    assign bus.pred_valid    = predPending;
    assign bus.global_bit    = predPending ? bus.tbl_rdata_g[1] : heldG;
    assign bus.choice_bit    = predPending ? bus.tbl_rdata_c[1] : heldC;
    assign bus.tbl_en        = tblEn;
    assign bus.tbl_we        = tblWe;
    assign bus.tbl_addr      = tblAddr;
    assign bus.tbl_wdata_g   = wdataG;
    assign bus.tbl_wdata_c   = wdataC;
    assign dbgState          = state;

`ifdef UPD_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_updates       <= '0;
            stat_lookup_stalls <= '0;
        end else begin
            if (state == WR && stat_updates != 16'hFFFF) begin
                stat_updates <= stat_updates + 16'd1;
            end
            if (bus.lookup_valid && !lookupReady && initDone &&
                stat_lookup_stalls != 16'hFFFF) begin
                stat_lookup_stalls <= stat_lookup_stalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_global_table_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_global_table_update_ctrl
//
// Directed bench for global_table_update_ctrl with HIST_W=4, QDEPTH=4.
// A behavioural single-port RAM answers the table port; expected values are
// hand-computed constants. Inputs change on the falling edge, outputs are
// checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_global_table_update_ctrl;
    localparam int HIST_W = 4;
    localparam int QDEPTH = 4;
    localparam int DEPTH  = 1 << HIST_W;

    logic       clock;
    logic       reset;
    logic [1:0] dbgState;

    int testsRun    = 0;
    int testsFailed = 0;

    global_table_update_ctrl_if #(.HIST_W(HIST_W)) bus ();

    global_table_update_ctrl #(.HIST_W(HIST_W), .QDEPTH(QDEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus.slave),
        .dbgState (dbgState)
    );

    // ------------------------------------------------------- clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------------------------------------------------- table RAM
    logic [1:0]        memG [DEPTH];
    logic [1:0]        memC [DEPTH];
    logic              pokeEn   = 1'b0;
    logic [HIST_W-1:0] pokeAddr = '0;
    logic [1:0]        pokeG    = 2'd0;
    logic [1:0]        pokeC    = 2'd0;

    initial begin
        bus.tbl_rdata_g = 2'd0;
        bus.tbl_rdata_c = 2'd0;
    end

    always @(posedge clock) begin
        if (pokeEn) begin
            memG[pokeAddr] <= pokeG;
            memC[pokeAddr] <= pokeC;
        end
        if (bus.tbl_en) begin
            if (bus.tbl_we) begin
                memG[bus.tbl_addr] <= bus.tbl_wdata_g;
                memC[bus.tbl_addr] <= bus.tbl_wdata_c;
            end else begin
                bus.tbl_rdata_g <= memG[bus.tbl_addr];
                bus.tbl_rdata_c <= memC[bus.tbl_addr];
            end
        end
    end

    // ------------------------------------------------------------ checking
    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------- driver tasks
    task automatic poke(input logic [HIST_W-1:0] a, input logic [1:0] g,
                        input logic [1:0] c);
        @(negedge clock);
        pokeEn = 1'b1; pokeAddr = a; pokeG = g; pokeC = c;
        @(negedge clock);
        pokeEn = 1'b0;
        #1;
    endtask

    task automatic offer(input logic [HIST_W-1:0] h, input logic t,
                         input logic gOk, input logic lOk);
        bus.resolve_valid     = 1'b1;
        bus.resolve_hist      = h;
        bus.resolve_taken     = t;
        bus.resolve_global_ok = gOk;
        bus.resolve_local_ok  = lOk;
    endtask

    // Entered at negedge+1 of the first cycle after reset release.
    task automatic checkSweep(input string tag);
        checkVal({tag, "_c0_en"}, {31'd0, bus.tbl_en}, 32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clock); #1;
            checkVal({tag, "_en_we"}, {30'd0, bus.tbl_en, bus.tbl_we}, 32'd3);
            checkVal({tag, "_addr"}, {28'd0, bus.tbl_addr}, k);
            checkVal({tag, "_wdata"}, {28'd0, bus.tbl_wdata_g, bus.tbl_wdata_c}, 32'd0);
            checkVal({tag, "_rdy_done"},
                     {29'd0, bus.lookup_ready, bus.resolve_ready, bus.init_done}, 32'd0);
        end
        @(negedge clock); #1;
        checkVal({tag, "_done"}, {31'd0, bus.init_done}, 32'd1);
        checkVal({tag, "_done_rdy"}, {30'd0, bus.lookup_ready, bus.resolve_ready}, 32'd3);
        checkVal({tag, "_done_port_idle"}, {31'd0, bus.tbl_en}, 32'd0);
        checkVal({tag, "_done_state"}, {30'd0, dbgState}, 32'd1);
    endtask

    // Single update into an empty queue with no lookups: enqueue, RD, WR.
    task automatic doUpdate(input string tag, input logic [HIST_W-1:0] h,
                            input logic t, input logic gOk, input logic lOk,
                            input logic [1:0] expG, input logic [1:0] expC);
        @(negedge clock);
        offer(h, t, gOk, lOk);
        #1;
        checkVal({tag, "_rready"}, {31'd0, bus.resolve_ready}, 32'd1);
        @(negedge clock);
        bus.resolve_valid = 1'b0;
        #1;
        checkVal({tag, "_rd"}, {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr},
                 {26'd0, 2'b10, h});
        @(negedge clock); #1;
        checkVal({tag, "_wr"}, {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr},
                 {26'd0, 2'b11, h});
        checkVal({tag, "_wdata"}, {28'd0, bus.tbl_wdata_g, bus.tbl_wdata_c},
                 {28'd0, expG, expC});
        checkVal({tag, "_wr_lready"}, {31'd0, bus.lookup_ready}, 32'd0);
    endtask

    // ---------------------------------------------------------- main flow
    initial begin
        bus.lookup_valid      = 1'b0;
        bus.lookup_hist       = '0;
        bus.resolve_valid     = 1'b0;
        bus.resolve_hist      = '0;
        bus.resolve_taken     = 1'b0;
        bus.resolve_global_ok = 1'b0;
        bus.resolve_local_ok  = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        checkVal("rst_port", {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, 32'd0);
        checkVal("rst_wdata", {28'd0, bus.tbl_wdata_g, bus.tbl_wdata_c}, 32'd0);
        checkVal("rst_flags", {26'd0, bus.lookup_ready, bus.resolve_ready, bus.init_done,
                 bus.pred_valid, bus.global_bit, bus.choice_bit}, 32'd0);
        checkVal("rst_state", {30'd0, dbgState}, 32'd0);

        @(negedge clock);
        reset = 1'b0;
        #1;
        checkSweep("init");

        // Lookup of a preloaded entry: g=3, c=1 -> global 1, choice 0.
        poke(4'd5, 2'd3, 2'd1);
        @(negedge clock);
        bus.lookup_valid = 1'b1; bus.lookup_hist = 4'd5;
        #1;
        checkVal("lk_ready", {31'd0, bus.lookup_ready}, 32'd1);
        checkVal("lk_rd", {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {26'd0, 2'b10, 4'd5});
        @(negedge clock);
        bus.lookup_valid = 1'b0;
        #1;
        checkVal("lk_pred", {29'd0, bus.pred_valid, bus.global_bit, bus.choice_bit}, 32'b110);
        @(negedge clock); #1;
        checkVal("lk_hold", {29'd0, bus.pred_valid, bus.global_bit, bus.choice_bit}, 32'b010);

        // Saturating increments of both counters on a cleared entry.
        doUpdate("inc1", 4'd2, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1);
        doUpdate("inc2", 4'd2, 1'b1, 1'b1, 1'b0, 2'd2, 2'd2);
        doUpdate("inc3", 4'd2, 1'b1, 1'b1, 1'b0, 2'd3, 2'd3);
        doUpdate("inc4_sat", 4'd2, 1'b1, 1'b1, 1'b0, 2'd3, 2'd3);
        @(negedge clock);
        bus.lookup_valid = 1'b1; bus.lookup_hist = 4'd2;
        @(negedge clock);
        bus.lookup_valid = 1'b0;
        #1;
        checkVal("inc_readback", {29'd0, bus.pred_valid, bus.global_bit, bus.choice_bit}, 32'b111);

        // Both predictors right: choice unchanged, global decremented.
        poke(4'd7, 2'd2, 2'd1);
        doUpdate("both_ok", 4'd7, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1);

        // Only local right: choice decrements and saturates at 0.
        poke(4'd9, 2'd0, 2'd2);
        doUpdate("loc1", 4'd9, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1);
        doUpdate("loc2", 4'd9, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0);
        doUpdate("loc3_sat", 4'd9, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);

        // Fill the queue while lookups stream.
        @(negedge clock);
        bus.lookup_valid = 1'b1; bus.lookup_hist = 4'd5;
        offer(4'd1, 1'b1, 1'b0, 1'b0);
        #1;
        checkVal("fill_a", {26'd0, bus.lookup_ready, bus.resolve_ready, bus.tbl_en,
                 bus.tbl_we, bus.tbl_addr}, {26'd0, 4'b1110, 4'd5});
        @(negedge clock);
        offer(4'd3, 1'b1, 1'b0, 1'b0);
        #1;
        checkVal("fill_b", {30'd0, bus.lookup_ready, bus.resolve_ready}, 32'd3);
        @(negedge clock);
        offer(4'd4, 1'b1, 1'b0, 1'b0);
        #1;
        checkVal("fill_c", {30'd0, bus.lookup_ready, bus.resolve_ready}, 32'd3);
        @(negedge clock);
        offer(4'd6, 1'b1, 1'b0, 1'b0);
        #1;
        checkVal("fill_d", {26'd0, bus.lookup_ready, bus.resolve_ready, bus.tbl_en,
                 bus.tbl_we, bus.tbl_addr}, {26'd0, 4'b1110, 4'd5});
        @(negedge clock);
        offer(4'd8, 1'b1, 1'b0, 1'b0);
        #1;
        checkVal("full_rd", {26'd0, bus.lookup_ready, bus.resolve_ready, bus.tbl_en,
                 bus.tbl_we, bus.tbl_addr}, {26'd0, 4'b0010, 4'd1});
        @(negedge clock); #1;
        checkVal("full_wr", {26'd0, bus.lookup_ready, bus.resolve_ready, bus.tbl_en,
                 bus.tbl_we, bus.tbl_addr}, {26'd0, 4'b0011, 4'd1});
        checkVal("full_wr_data", {28'd0, bus.tbl_wdata_g, bus.tbl_wdata_c}, 32'b0100);
        @(negedge clock);
        bus.resolve_valid = 1'b0;
        #1;
        checkVal("resume_lk", {26'd0, bus.lookup_ready, bus.resolve_ready, bus.tbl_en,
                 bus.tbl_we, bus.tbl_addr}, {26'd0, 4'b1110, 4'd5});
        @(negedge clock);
        bus.lookup_valid = 1'b0;
        #1;
        checkVal("resume_pred", {29'd0, bus.pred_valid, bus.global_bit, bus.choice_bit}, 32'b110);
        checkVal("drain_rd3", {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {26'd0, 2'b10, 4'd3});
        @(negedge clock); #1;
        checkVal("drain_wr3", {24'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr,
                 bus.tbl_wdata_g, bus.tbl_wdata_c}, {24'd0, 2'b11, 4'd3, 4'b0100});
        @(negedge clock); #1;
        checkVal("drain_rd4", {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {26'd0, 2'b10, 4'd4});
        @(negedge clock); #1;
        checkVal("drain_wr4", {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {26'd0, 2'b11, 4'd4});
        @(negedge clock); #1;
        checkVal("drain_rd6", {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {26'd0, 2'b10, 4'd6});
        @(negedge clock); #1;
        checkVal("drain_wr6", {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {26'd0, 2'b11, 4'd6});
        @(negedge clock); #1;
        checkVal("drain_empty", {31'd0, bus.tbl_en}, 32'd0);

        // Reset in the middle of a write with another update still queued.
        @(negedge clock);
        offer(4'd10, 1'b1, 1'b0, 1'b0);
        #1;
        checkVal("mid_enq_idle", {31'd0, bus.tbl_en}, 32'd0);
        @(negedge clock);
        offer(4'd11, 1'b1, 1'b0, 1'b0);
        #1;
        checkVal("mid_rd", {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {26'd0, 2'b10, 4'd10});
        @(negedge clock);
        bus.resolve_valid = 1'b0;
        #1;
        checkVal("mid_wr", {26'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {26'd0, 2'b11, 4'd10});
        #1 reset = 1'b1;
        #1;
        checkVal("mid_rst_port", {22'd0, bus.tbl_en, bus.tbl_we, bus.tbl_addr,
                 bus.tbl_wdata_g, bus.tbl_wdata_c}, 32'd0);
        checkVal("mid_rst_flags", {26'd0, bus.lookup_ready, bus.resolve_ready, bus.init_done,
                 bus.pred_valid, bus.global_bit, bus.choice_bit}, 32'd0);
        checkVal("mid_rst_state", {30'd0, dbgState}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkSweep("reinit");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
